// File: rtl/alu_issue_unit.sv
// Issue/writeback stage around the 16-bit multiplexer ALU, with a small register file and retired counter.
// Accept edge -> writeback one edge later; in_ready drops for the EXEC cycle (1 instr / 2 cycles).
module alu_issue_unit #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [AW-1:0]    in_ra,
  input  logic [AW-1:0]    in_rb,
  input  logic [AW-1:0]    in_rd,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  output logic [1:0]       opCode,
  output logic [WIDTH-1:0] inputA,
  output logic [WIDTH-1:0] inputB,
  input  logic [WIDTH-1:0] result,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             illegal,
  output logic [15:0]      retired
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             wb_valid_q, wb_valid_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             illegal_q, illegal_d;
  logic [15:0]      retired_q, retired_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    retired_d  = retired_q;
    regs_d     = regs_q;

    // Preload goes first so a same-edge writeback to the same address overrides it.
    if (load_en) regs_d[load_addr] = load_data;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          state_d    = EXEC;
          in_ready_d = 1'b0;
          op_d       = in_op;
          a_d        = (load_en && load_addr == in_ra) ? load_data : regs_q[in_ra];
          b_d        = (load_en && load_addr == in_rb) ? load_data : regs_q[in_rb];
          rd_d       = in_rd;
        end
      end
      EXEC: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        if (op_q == 2'b11) begin
          illegal_d = 1'b1;
        end else begin
          regs_d[rd_q] = result;
          wb_valid_d   = 1'b1;
          wb_addr_d    = rd_q;
          wb_data_d    = result;
          retired_d    = retired_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign in_ready = in_ready_q;
  assign opCode   = op_q;
  assign inputA   = a_q;
  assign inputB   = b_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed cases plus random traffic against a transaction-level register-file model.
module tb_alu_issue_unit;

  logic        clock, clear;
  logic        in_valid, in_ready;
  logic [1:0]  in_op, in_ra, in_rb, in_rd;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [15:0] load_data;
  logic [1:0]  opCode;
  logic [15:0] inputA, inputB, result;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_unit dut (
    .clock(clock), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .opCode(opCode), .inputA(inputA), .inputB(inputB), .result(result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .retired(retired)
  );

  // External combinational multiplexer; op 11 yields junk that must never be written.
  assign result = (opCode == 2'b00) ? inputA + inputB :
                  (opCode == 2'b01) ? inputA - inputB :
                  (opCode == 2'b10) ? ~inputA : 16'hDEAD;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      default: return ~a;
    endcase
  endfunction

  // Reference model: the register file as an array, one in-flight instruction, results queued for the monitor.
  typedef struct { logic ill; logic [1:0] addr; logic [15:0] data; } exp_t;
  exp_t        q[$];
  logic [15:0] m_regs [4];
  logic        m_ready, m_busy;
  logic [1:0]  m_op, m_rd;
  logic [15:0] m_a, m_b, m_res, m_retired, m_wb_data;
  logic [1:0]  m_wb_addr;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
      m_ready = 0; m_busy = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0;
      m_retired = 0; m_wb_addr = 0; m_wb_data = 0;
      q.delete();
    end else if (m_busy) begin
      if (load_en) m_regs[load_addr] = load_data;
      if (m_op == 2'b11) begin
        q.push_back('{1'b1, m_rd, 16'h0});
      end else begin
        m_res = alu(m_op, m_a, m_b);
        m_regs[m_rd] = m_res;
        m_retired = m_retired + 16'd1;
        m_wb_addr = m_rd;
        m_wb_data = m_res;
        q.push_back('{1'b0, m_rd, m_res});
      end
      m_busy = 0; m_ready = 1;
    end else begin
      if (in_valid && m_ready) begin
        m_op = in_op;
        m_rd = in_rd;
        m_a  = (load_en && load_addr == in_ra) ? load_data : m_regs[in_ra];
        m_b  = (load_en && load_addr == in_rb) ? load_data : m_regs[in_rb];
        m_busy = 1; m_ready = 0;
      end else begin
        m_ready = 1;
      end
      if (load_en) m_regs[load_addr] = load_data;
    end
  end

  // Monitor: every expected result must appear exactly on the next falling edge after the model produces it.
  always @(negedge clock) begin
    exp_t e;
    logic exp_wbv, exp_ill;
    exp_wbv = 0; exp_ill = 0;
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_wbv = !e.ill;
      exp_ill = e.ill;
      if (!e.ill) begin
        chk("wb_addr", wb_addr, e.addr);
        chk("wb_data", wb_data, e.data);
      end
    end
    chk("wb_valid", wb_valid, exp_wbv);
    chk("illegal", illegal, exp_ill);
    chk("in_ready", in_ready, m_ready);
    chk("opCode", opCode, m_op);
    chk("inputA", inputA, m_a);
    chk("inputB", inputB, m_b);
    chk("retired", retired, m_retired);
    chk("wb_addr_hold", wb_addr, m_wb_addr);
    chk("wb_data_hold", wb_data, m_wb_data);
  end

  task automatic do_load(input logic [1:0] a, input logic [15:0] d);
    load_en = 1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 0;
  endtask

  // Returns on the falling edge inside the EXEC cycle.
  task automatic issue(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                       input logic le, input logic [1:0] la, input logic [15:0] ld);
    int n;
    in_valid = 1; in_op = op; in_ra = ra; in_rb = rb; in_rd = rd;
    load_en = le; load_addr = la; load_data = ld;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n == 20) begin
      miscompares++;
      $display("FAIL handshake: in_ready stuck at 0, expected 1");
    end
    @(negedge clock);
    in_valid = 0; load_en = 0;
  endtask

  initial begin
    clear = 0; in_valid = 0; in_op = 0; in_ra = 0; in_rb = 0; in_rd = 0;
    load_en = 0; load_addr = 0; load_data = 0;
    #12;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_retired", retired, 0);
    clear = 1;
    @(negedge clock);

    // 1: add
    do_load(0, 16'd805);
    do_load(1, 16'd302);
    issue(2'b00, 0, 1, 2, 0, 0, 0);
    chk("t1_busy", in_ready, 0);
    @(negedge clock);
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_data", wb_data, 16'd1107);

    // 2: sub then not
    issue(2'b01, 0, 1, 3, 0, 0, 0);
    @(negedge clock);
    chk("t2_sub", wb_data, 16'd503);
    issue(2'b10, 1, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("t2_not", wb_data, 16'hFED1);
    chk("t2_retired", retired, 3);

    // 3: back-to-back with in_valid held
    issue(2'b00, 2, 3, 1, 0, 0, 0);
    issue(2'b01, 2, 3, 0, 0, 0, 0);
    @(negedge clock);
    chk("t3_second_wb", wb_addr, 0);

    // 4: wrap and illegal
    do_load(0, 16'hFFFF);
    do_load(1, 16'd1);
    issue(2'b00, 0, 1, 2, 0, 0, 0);
    @(negedge clock);
    chk("t4_wrap", wb_data, 0);
    issue(2'b11, 0, 1, 2, 0, 0, 0);
    @(negedge clock);
    chk("t4_illegal", illegal, 1);
    chk("t4_no_wb", wb_valid, 0);
    issue(2'b10, 2, 2, 3, 0, 0, 0);
    chk("t4_r2_kept", inputA, 0);

    // 5: operand bypass, and writeback beating a same-edge load
    @(negedge clock);
    do_load(0, 16'd5);
    issue(2'b00, 0, 1, 2, 1, 1, 16'd7);
    chk("t5_bypass", inputB, 7);
    @(negedge clock);
    chk("t5_sum", wb_data, 16'd12);
    issue(2'b00, 0, 0, 3, 0, 0, 0);
    do_load(3, 16'h1234);
    chk("t5_wb", wb_data, 16'd10);
    issue(2'b10, 3, 0, 1, 0, 0, 0);
    chk("t5_wb_wins", inputA, 16'd10);
    @(negedge clock);

    // 6: reset mid-EXEC
    issue(2'b00, 0, 1, 2, 0, 0, 0);
    #2 clear = 0;
    @(negedge clock);
    chk("t6_no_wb", wb_valid, 0);
    chk("t6_retired", retired, 0);
    chk("t6_ready", in_ready, 0);
    #2 clear = 1;
    @(negedge clock);
    chk("t6_ready_after", in_ready, 1);
    issue(2'b00, 0, 3, 1, 0, 0, 0);
    chk("t6_regs_zero", {inputA, inputB}, 0);
    @(negedge clock);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) do_load(2'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clock);
      issue(($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            2'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 2) == 0, 2'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) do_load(2'($urandom), 16'($urandom));
    end
    repeat (4) @(negedge clock);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
